bnn_ctrl: RTL and testbench

Sequencing controller for the binarized neural network core (`bnn` plus its `parameters` ROM, wrapped by `top`). The core is purely combinational. This block turns it into a clocked, handshaked accelerator for the ChipWhisperer CW305 target:
- registers the 64-bit input image into the core;
- waits a programmable settle window while asserting a scope trigger;
- captures the 10 class scores;
- scans them sequentially for the argmax;
- signals completion with a one-cycle pulse.

---
 rtl/bnn_ctrl_pkg.sv | 25 ++
 rtl/bnn_ctrl_argmax.sv | 43 ++++
 rtl/bnn_ctrl.sv | 114 +++++++++++
 tb/tb_bnn_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bnn_ctrl_pkg.sv
// Shared types, default sizes and score-extraction helper for the bnn_ctrl
// sequencing controller around the combinational BNN core.
package bnn_ctrl_pkg;

  localparam int IN_BITS   = 64;
  localparam int N_CLASSES = 10;
  localparam int SCORE_W   = 5;
  localparam int CLS_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Score of class k from the packed core output vector (default sizes).
  function automatic logic [SCORE_W-1:0] class_score(
    input logic [N_CLASSES*SCORE_W-1:0] scores,
    input int unsigned                  k
  );
    return scores[k*SCORE_W +: SCORE_W];
  endfunction

endpackage

// File: rtl/bnn_ctrl_argmax.sv
// Sequential argmax over the captured class scores, one class per enabled
// cycle; start clears the scan and last flags the final class.
module bnn_ctrl_argmax #(
  parameter int N_CLASSES = bnn_ctrl_pkg::N_CLASSES,
  parameter int SCORE_W   = bnn_ctrl_pkg::SCORE_W,
  parameter int CLS_W     = bnn_ctrl_pkg::CLS_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         en,
  input  logic [N_CLASSES*SCORE_W-1:0] scores,
  output logic [CLS_W-1:0]             cls,
  output logic [SCORE_W-1:0]           max_score,
  output logic                         last
);

  logic [CLS_W-1:0]   idx_r;
  logic [SCORE_W-1:0] cur_s;

  assign cur_s = scores[idx_r*SCORE_W +: SCORE_W];
  assign last  = (idx_r == CLS_W'(N_CLASSES - 1));

  // Strict compare keeps the lowest index on ties and class 0 for all-zero scores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r     <= '0;
      cls       <= '0;
      max_score <= '0;
    end else if (start) begin
      idx_r     <= '0;
      cls       <= '0;
      max_score <= '0;
    end else if (en) begin
      if (cur_s > max_score) begin
        max_score <= cur_s;
        cls       <= idx_r;
      end
      idx_r <= last ? '0 : idx_r + CLS_W'(1);
    end
  end

endmodule

// File: rtl/bnn_ctrl.sv
// Clocked, handshaked sequencer for the combinational BNN core: image register,
// settle window with scope trigger, score capture, argmax scan, done pulse.
// Optional macro BNN_CTRL_CLEAR_EN zeroes layer_o in the DONE cycle.
module bnn_ctrl
  import bnn_ctrl_pkg::*;
#(
  parameter int IN_BITS       = bnn_ctrl_pkg::IN_BITS,
  parameter int N_CLASSES     = bnn_ctrl_pkg::N_CLASSES,
  parameter int SCORE_W       = bnn_ctrl_pkg::SCORE_W,
  parameter int CLS_W         = bnn_ctrl_pkg::CLS_W,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [IN_BITS-1:0]           image_i,
  output logic [IN_BITS-1:0]           layer_o,
  input  logic [N_CLASSES*SCORE_W-1:0] scores_i,
  output logic [N_CLASSES*SCORE_W-1:0] scores_o,
  output logic [CLS_W-1:0]             class_o,
  output logic [SCORE_W-1:0]           score_max_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         trigger_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             scan_start_s;
  logic             scan_en_s;
  logic             scan_last_s;

  assign scan_start_s = (state_r == ST_SETTLE) && (cnt_r == '0);
  assign scan_en_s    = (state_r == ST_ARGMAX);

  bnn_ctrl_argmax #(
    .N_CLASSES (N_CLASSES),
    .SCORE_W   (SCORE_W),
    .CLS_W     (CLS_W)
  ) u_argmax (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (scan_start_s),
    .en        (scan_en_s),
    .scores    (scores_o),
    .cls       (class_o),
    .max_score (score_max_o),
    .last      (scan_last_s)
  );

  // Control FSM; trigger/busy/done are set on the transition into their states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      layer_o   <= '0;
      scores_o  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      trigger_o <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            layer_o   <= image_i;
            cnt_r     <= CNT_W'(SETTLE_CYCLES - 1);
            state_r   <= ST_SETTLE;
            busy_o    <= 1'b1;
            trigger_o <= 1'b1;
            done_o    <= 1'b0;
          end else begin
            state_r   <= ST_IDLE;
            busy_o    <= 1'b0;
            trigger_o <= 1'b0;
            done_o    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          // The core output is only trusted on the last settle cycle.
          if (cnt_r == '0) begin
            scores_o  <= scores_i;
            state_r   <= ST_ARGMAX;
            trigger_o <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_ARGMAX: begin
          if (scan_last_s) begin
            state_r <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
`ifdef BNN_CTRL_CLEAR_EN
            layer_o <= '0;
`else
            layer_o <= layer_o;
`endif
          end else begin
            state_r <= ST_ARGMAX;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
          trigger_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_ctrl.sv
// Self-checking bench for bnn_ctrl: cycle-level behavioural model with a
// per-cycle compare process, directed scenarios with literal expectations,
// then randomized traffic including asynchronous resets.
module tb_bnn_ctrl;
  import bnn_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] image = 64'd0;
  logic [49:0] scores = 50'd0;
  logic [63:0] layer;
  logic [49:0] scores_q;
  logic [3:0]  cls;
  logic [4:0]  smax;
  logic        busy, done, trigger;

  int n_pass = 0;
  int n_total = 0;

  bnn_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .image_i(image),
    .layer_o(layer), .scores_i(scores), .scores_o(scores_q),
    .class_o(cls), .score_max_o(smax), .busy_o(busy), .done_o(done),
    .trigger_o(trigger)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Max over the first n classes, then the lowest index holding that max.
  function automatic void prefix_argmax(input logic [49:0] s, input int n,
                                        output logic [3:0] c, output logic [4:0] m);
    int best;
    best = 0;
    for (int k = 0; k < n; k++)
      if (int'(class_score(s, k)) > best) best = int'(class_score(s, k));
    m = 5'(best);
    c = 4'd0;
    for (int k = n - 1; k >= 0; k--)
      if (int'(class_score(s, k)) == best) c = 4'(k);
  endfunction

  // Model: everything follows from the cycle offset since the last accepted start.
  int          cyc = 0;
  int          acc = 0;
  bit          have = 1'b0;
  logic [49:0] cap = 50'd0;
  logic [63:0] lay = 64'd0;
  logic [63:0] e_layer = 64'd0;
  logic [49:0] e_scores = 50'd0;
  logic [3:0]  e_cls = 4'd0;
  logic [4:0]  e_max = 5'd0;
  bit          e_busy = 1'b0, e_done = 1'b0, e_trig = 1'b0;

  always @(negedge clk) begin
    int d, dn;
    bit busy_now;
    if (rst) begin
      have = 1'b0; cap = 50'd0; lay = 64'd0;
      e_layer = 64'd0; e_scores = 50'd0; e_cls = 4'd0; e_max = 5'd0;
      e_busy = 1'b0; e_done = 1'b0; e_trig = 1'b0;
    end
    chk("layer", layer, e_layer);
    chk("scores", 64'(scores_q), 64'(e_scores));
    chk("class", 64'(cls), 64'(e_cls));
    chk("score_max", 64'(smax), 64'(e_max));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("trigger", 64'(trigger), 64'(e_trig));
    if (!rst) begin
      d = cyc - acc;
      busy_now = have && d >= 1 && d <= 14;
      if (have && d == 4) cap = scores;
      if (start && !busy_now) begin
        have = 1'b1; acc = cyc; lay = image;
      end
      dn = cyc + 1 - acc;
      e_trig = have && dn >= 1 && dn <= 4;
      e_busy = have && dn >= 1 && dn <= 14;
      e_done = have && dn == 15;
      if (have && dn >= 5 && dn <= 15) prefix_argmax(cap, dn - 5, e_cls, e_max);
`ifdef BNN_CTRL_CLEAR_EN
      if (have && dn == 15) lay = 64'd0;
`endif
      e_layer = lay;
      e_scores = cap;
    end
    cyc++;
  end

  function automatic logic [49:0] mk_scores(input int mode);
    logic [49:0] s;
    s = 50'd0;
    for (int k = 0; k < 10; k++) begin
      case (mode)
        0: s[k*5 +: 5] = (k == 7) ? 5'd31 : 5'($urandom_range(10));
        1: s[k*5 +: 5] = (k == 2 || k == 5) ? 5'd20 : 5'd3;
        2: s[k*5 +: 5] = 5'd0;
        default: s[k*5 +: 5] = ($urandom_range(1) == 0) ? 5'($urandom_range(31))
                                                        : 5'($urandom_range(3));
      endcase
    end
    return s;
  endfunction

  task automatic directed(input string name, input logic [49:0] sc, input logic [3:0] ecls,
                          input logic [4:0] emax, input bit ign, input bit do_rst, input bit b2b);
    logic [63:0] a, b;
    int trig_n, trig_first, done_n, done_first, done_second;
    a = {$urandom, $urandom};
    b = ~a;
    trig_n = 0; trig_first = -1; done_n = 0; done_first = -1; done_second = -1;
    for (int i = 0; i <= 31; i++) begin
      @(posedge clk); #1;
      start  = (i == 0) || (ign && i == 3) || (b2b && i == 15);
      image  = (i == 0) ? a : b;
      scores = (ign && i >= 6) ? ~sc : sc;
      if (do_rst && i == 6) rst = 1'b1;
      if (do_rst && i == 8) rst = 1'b0;
      @(negedge clk);
      if (i >= 1 && trigger) begin
        trig_n++;
        if (trig_first < 0) trig_first = i;
      end
      if (done) begin
        done_n++;
        if (done_first < 0) done_first = i;
        else if (done_second < 0) done_second = i;
      end
      if (ign && i >= 1 && i <= 14) chk({name, "_layer_hold"}, layer, a);
      if (do_rst && i == 6) begin
        chk({name, "_rst_layer"}, layer, 64'd0);
        chk({name, "_rst_outs"}, 64'({scores_q, cls, smax, busy, done, trigger}), 64'd0);
      end
      if (!do_rst && i == 15) begin
        chk({name, "_class"}, 64'(cls), 64'(ecls));
        chk({name, "_max"}, 64'(smax), 64'(emax));
`ifdef BNN_CTRL_CLEAR_EN
        chk({name, "_layer_done"}, layer, 64'd0);
`else
        chk({name, "_layer_done"}, layer, a);
`endif
      end
    end
    start = 1'b0;
    if (do_rst) begin
      chk({name, "_no_done"}, 64'(done_n), 64'd0);
    end else begin
      chk({name, "_trig_first"}, 64'(trig_first), 64'd1);
      chk({name, "_trig_len"}, 64'(trig_n), b2b ? 64'd8 : 64'd4);
      chk({name, "_done_at"}, 64'(done_first), 64'd15);
      chk({name, "_done_n"}, 64'(done_n), b2b ? 64'd2 : 64'd1);
      if (b2b) chk({name, "_done2_at"}, 64'(done_second), 64'd30);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    directed("single_max", mk_scores(0), 4'd7, 5'd31, 1'b0, 1'b0, 1'b0);
    directed("tie", mk_scores(1), 4'd2, 5'd20, 1'b0, 1'b0, 1'b0);
    directed("all_zero", mk_scores(2), 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    directed("ignored_start", mk_scores(1), 4'd2, 5'd20, 1'b1, 1'b0, 1'b0);
    directed("reset_mid", mk_scores(0), 4'd7, 5'd31, 1'b0, 1'b1, 1'b0);
    directed("after_reset", mk_scores(0), 4'd7, 5'd31, 1'b0, 1'b0, 1'b0);
    directed("back_to_back", mk_scores(1), 4'd2, 5'd20, 1'b0, 1'b0, 1'b1);
    repeat (3000) begin
      @(posedge clk); #1;
      start = ($urandom_range(3) == 0);
      image = {$urandom, $urandom};
      if ($urandom_range(3) == 0) scores = mk_scores(3);
      if (rst) rst = 1'b0;
      else if ($urandom_range(199) == 0) rst = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
